// File: rtl/div47_seq_ctrl.sv
// Digit-serial sequencer for the 60-bit divide-by-47 datapath: feeds an external radix-8
// step unit MSB digit first, gathers quotient digits and returns quotient/remainder.
module div47_seq_ctrl #(
   parameter int unsigned N   = 60,
   parameter int unsigned D_W = 3,
   parameter int unsigned R_W = 6,
   parameter int unsigned DIV = 47
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_in_valid,
   output logic           o_in_ready,
   input  logic [N-1:0]   i_in_dividend,
   output logic [R_W-1:0] o_step_res,
   output logic [D_W-1:0] o_step_digit,
   input  logic [D_W-1:0] i_step_q,
   input  logic [R_W-1:0] i_step_r,
   output logic           o_out_valid,
   input  logic           i_out_ready,
   output logic [N-1:0]   o_out_quot,
   output logic [R_W-1:0] o_out_rem,
   output logic           o_err,
   output logic           o_busy
);

   localparam int unsigned STEPS = N / D_W;
   localparam int unsigned CNT_W = $clog2(STEPS);
   localparam int unsigned CHK_W = R_W + D_W + 1;
   localparam logic [CHK_W-1:0] DIV_C = CHK_W'(DIV);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             r_state, w_state_nxt;
   logic [N-1:0]       r_div, w_div_nxt;
   logic [N-1:0]       r_quot, w_quot_nxt;
   logic [R_W-1:0]     r_res, w_res_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_err, w_err_nxt;

   logic [CHK_W-1:0]   w_lhs, w_rhs;
   logic               w_fault;

   // Step unit must satisfy q*DIV + r == res*2^D_W + digit with r < DIV.
   assign w_lhs   = CHK_W'(i_step_q) * DIV_C + CHK_W'(i_step_r);
   assign w_rhs   = {1'b0, r_res, r_div[N-1 -: D_W]};
   assign w_fault = (CHK_W'(i_step_r) >= DIV_C) || (w_lhs != w_rhs);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_div   <= '0;
         r_quot  <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_quot  <= w_quot_nxt;
         r_res   <= w_res_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_quot_nxt  = r_quot;
      w_res_nxt   = r_res;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      unique case (r_state)
         StIdle: begin
            if (i_in_valid) begin
               w_div_nxt   = i_in_dividend;
               w_quot_nxt  = '0;
               w_res_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            w_res_nxt  = i_step_r;
            w_quot_nxt = {r_quot[N-D_W-1:0], i_step_q};
            w_div_nxt  = {r_div[N-D_W-1:0], {D_W{1'b0}}};
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            if (w_fault) begin
               w_err_nxt = 1'b1;
            end
            if (r_cnt == CNT_W'(STEPS - 1)) begin
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            if (i_out_ready) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign o_in_ready   = (r_state == StIdle);
   assign o_out_valid  = (r_state == StDone);
   assign o_busy       = (r_state != StIdle);
   assign o_step_res   = r_res;
   assign o_step_digit = r_div[N-1 -: D_W];
   assign o_out_quot   = r_quot;
   assign o_out_rem    = r_res;
   assign o_err        = r_err;

endmodule

// File: tb/tb_div47_seq_ctrl.sv
// Bench for div47_seq_ctrl: behavioural radix-8 step unit with fault injection, and a
// scoreboard of expected quotient/remainder pairs checked at each result handshake.
module tb_div47_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [59:0] in_dividend;
   logic [5:0]  step_res;
   logic [2:0]  step_digit;
   logic [2:0]  step_q;
   logic [5:0]  step_r;
   logic        out_valid;
   logic        out_ready;
   logic [59:0] out_quot;
   logic [5:0]  out_rem;
   logic        err;
   logic        busy;

   logic        force_r = 1'b0;
   logic        force_q = 1'b0;

   typedef struct {
      logic [59:0] q;
      logic [5:0]  r;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   div47_seq_ctrl dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_in_valid    (in_valid),
      .o_in_ready    (in_ready),
      .i_in_dividend (in_dividend),
      .o_step_res    (step_res),
      .o_step_digit  (step_digit),
      .i_step_q      (step_q),
      .i_step_r      (step_r),
      .o_out_valid   (out_valid),
      .i_out_ready   (out_ready),
      .o_out_quot    (out_quot),
      .o_out_rem     (out_rem),
      .o_err         (err),
      .o_busy        (busy)
   );

   // Reference step unit: (res*8 + digit) divided by 47
   logic [9:0] m_val, m_q, m_r;
   always_comb begin
      m_val  = {1'b0, step_res, step_digit};
      m_q    = m_val / 10'd47;
      m_r    = m_val % 10'd47;
      step_q = m_q[2:0] + (force_q ? 3'd1 : 3'd0);
      step_r = force_r ? 6'd50 : m_r[5:0];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      force_r   = 1'b0;
      force_q   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
   endtask

   // Called at a negedge; returns #1 after the accept edge.
   task automatic send(input logic [59:0] d);
      int   t = 0;
      exp_t e;
      logic [63:0] dd;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_before_send", {63'd0, in_ready}, 64'd1);
      in_valid    = 1'b1;
      in_dividend = d;
      @(posedge clk);
      dd  = {4'd0, d};
      e.q = 60'(dd / 64'd47);
      e.r = 6'(dd % 64'd47);
      sb.push_back(e);
      #1;
      in_valid    = 1'b0;
      in_dividend = {$urandom(), $urandom()} >> 4;
   endtask

   task automatic wait_result(input int exp_lat, input bit chk_dig, input int hold,
                              input bit cmp, input logic exp_err);
      int          k      = 0;
      int          dig    = 0;
      bit          stable = 1'b1;
      bit          rdy_lo = 1'b1;
      logic [59:0] q0;
      logic [5:0]  r0;
      exp_t        e;
      @(negedge clk);
      while (!out_valid && k < 200) begin
         if (busy && step_digit == 3'b111) dig++;
         @(negedge clk);
         k++;
      end
      check("out_valid_seen", {63'd0, out_valid}, 64'd1);
      if (!out_valid) return;
      if (exp_lat >= 0) check("latency", 64'(k), 64'(exp_lat));
      if (chk_dig) check("digits_all_111", 64'(dig), 64'd20);
      q0 = out_quot;
      r0 = out_rem;
      repeat (hold) begin
         @(negedge clk);
         if (out_quot !== q0 || out_rem !== r0 || !out_valid) stable = 1'b0;
         if (in_ready !== 1'b0) rdy_lo = 1'b0;
      end
      if (hold > 0) begin
         check("hold_outputs_stable", {63'd0, stable}, 64'd1);
         check("hold_in_ready_low", {63'd0, rdy_lo}, 64'd1);
      end
      out_ready = 1'b1;
      check("scoreboard_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (cmp) begin
            check("quot", {4'd0, out_quot}, {4'd0, e.q});
            check("rem", {58'd0, out_rem}, {58'd0, e.r});
         end
      end
      check("err", {63'd0, err}, {63'd0, exp_err});
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
      check("post_hs_out_valid", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      in_dividend = '0;
      do_reset();
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_quot", {4'd0, out_quot}, 64'd0);
      check("rst_rem", {58'd0, out_rem}, 64'd0);
      check("rst_step_res", {58'd0, step_res}, 64'd0);
      check("rst_step_digit", {61'd0, step_digit}, 64'd0);

      send(60'd0);    wait_result(20, 1'b0, 0, 1'b1, 1'b0);
      send(60'd47);   wait_result(20, 1'b0, 0, 1'b1, 1'b0);
      send(60'd1000); wait_result(20, 1'b0, 0, 1'b1, 1'b0);
      send(60'd46);   wait_result(20, 1'b0, 0, 1'b1, 1'b0);
      send({60{1'b1}});
      wait_result(20, 1'b1, 0, 1'b1, 1'b0);
      check("allones_quot_const", {4'd0, out_quot}, 64'd24530244778869084);

      // Backpressure with a waiting dividend held on the input throughout
      send(60'd1000);
      in_valid    = 1'b1;
      in_dividend = 60'd94;
      wait_result(20, 1'b0, 10, 1'b1, 1'b0);
      send(60'd94);
      wait_result(20, 1'b0, 0, 1'b1, 1'b0);

      // Reset during step 7
      send(60'd5000);
      repeat (8) @(negedge clk);
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      check("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("midrun_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrun_rst_busy", {63'd0, busy}, 64'd0);
      send(60'd1000); wait_result(20, 1'b0, 0, 1'b1, 1'b0);

      // Out-of-range residue on one step
      send(60'd200);
      repeat (3) @(negedge clk);
      force_r = 1'b1;
      check("err_before_bad_r", {63'd0, err}, 64'd0);
      @(negedge clk);
      force_r = 1'b0;
      check("err_after_bad_r", {63'd0, err}, 64'd1);
      wait_result(-1, 1'b0, 0, 1'b0, 1'b1);
      send(60'd47);   wait_result(20, 1'b0, 0, 1'b1, 1'b1);

      do_reset();
      check("err_cleared_by_rst", {63'd0, err}, 64'd0);

      // Quotient digit off by one on one step
      send(60'd500);
      repeat (5) @(negedge clk);
      force_q = 1'b1;
      check("err_before_bad_q", {63'd0, err}, 64'd0);
      @(negedge clk);
      force_q = 1'b0;
      check("err_after_bad_q", {63'd0, err}, 64'd1);
      wait_result(-1, 1'b0, 0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/div47_seq_ctrl.md
Name: div47_seq_ctrl

Overview:
- Digit-serial sequencer for the 60-bit divide-by-47 datapath.
- Accepts a 60-bit dividend and drives an external combinational radix-8 quotient/residue step unit once per cycle, MSB digit first, for 20 cycles.
- Collects the 3-bit quotient digits and returns the 60-bit quotient and 6-bit remainder over a valid/ready handshake.
- Sits between the operand pipeline and the result FIFO of the constant-division unit.

Parameters:
- N, 60, dividend/quotient width in bits; must be a multiple of D_W.
- D_W, 3, dividend digit width consumed per step.
- R_W, 6, residue width; must satisfy 2^R_W > DIV.
- DIV, 47, constant divisor; used only for the residue range check.
- STEPS, N/D_W (20), derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  dividend valid.
- in_ready  out  1  block can accept a dividend.
- in_dividend  in  N  dividend, unsigned.
- step_res  out  R_W  current residue to step unit.
- step_digit  out  D_W  current dividend digit to step unit.
- step_q  in  D_W  quotient digit from step unit (combinational).
- step_r  in  R_W  next residue from step unit (combinational).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_quot  out  N  quotient.
- out_rem  out  R_W  remainder.
- err  out  1  sticky residue-range error.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-low: `rst_n` is sampled on the rising edge of `clk`.
- Reset values:
  - state = IDLE.
  - in_ready = 1; out_valid = 0; busy = 0; err = 0.
  - out_quot = 0; out_rem = 0.
  - Internal residue, dividend shift register and step counter = 0.
- Reset has priority over every other event. Asserting it mid-RUN or in DONE abandons the operation immediately. No result is produced, and the next cycle after release is IDLE.
- States:
  - IDLE: in_ready = 1. A transfer occurs when in_valid & in_ready. On transfer:
    - load the dividend register;
    - clear residue and quotient to 0;
    - set cnt = 0;
    - go to RUN.
  - RUN: in_ready = 0.
    - step_res = residue register; step_digit = dividend register bits [N-1 -: D_W]. Both come directly from registers, so the step unit is the only logic in the path.
    - Each cycle: residue <= step_r; quotient <= {quotient[N-D_W-1:0], step_q}; dividend shifts left by D_W; cnt increments.
    - When cnt == STEPS-1 is processed, go to DONE.
  - DONE:
    - out_valid = 1; out_quot = quotient register; out_rem = residue register.
    - Outputs stay stable while out_ready = 0.
    - When out_valid & out_ready, go to IDLE.
- No accept in DONE: in_ready goes high only in the cycle after the result is consumed. There is no overlap and no bypass.
- Latency:
  - Input accepted at edge E.
  - Digits are processed on edges E+1 … E+20.
  - out_valid is high from edge E+20; the earliest result handshake is the cycle after E+20.
  - Throughput: one division per 22 cycles with out_ready held high.
- step_res and step_digit outside RUN: driven from the registers (don't-care to the step unit). They must not be X after reset.
- Range check: in RUN, if step_r >= DIV or step_q arithmetic is inconsistent, err is set.
  - Consistency rule: step_q*DIV + step_r != step_res*2^D_W + step_digit (compare at width R_W+D_W+1).
  - err is sticky; only rst_n clears it. The result is still delivered.
- in_dividend is sampled only at the transfer edge. Later changes are ignored.
- out_quot and out_rem hold their last values in IDLE. They are meaningful only while out_valid = 1.
- Implementation: one counter of ceil(log2(STEPS)) bits, plus N-bit dividend and quotient shift registers.

Test Plan:
- Dividend 0 -> out_quot 0, out_rem 0, err 0; out_valid rises exactly 20 edges after the accept edge.
- Dividend 47 -> quot 1, rem 0. Dividend 1000 -> quot 21, rem 13. Dividend 46 -> quot 0, rem 46.
- Dividend 2^60-1 -> quot 24530244778869084, rem 27. Check that step_digit is 3'b111 on all 20 RUN cycles.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE; outputs stay stable and in_ready stays 0.
  - Keep in_valid asserted with a new dividend 94 throughout; it is accepted only after the result handshake and yields quot 2, rem 0.
- Reset mid-RUN: pull rst_n low at step 7 -> next cycle shows IDLE, in_ready 1, out_valid 0. A following dividend 1000 gives quot 21, rem 13.
- Faulty step model:
  - Force step_r = 50 on one step -> err rises on the next edge and stays high through the result handshake and the following operations, until rst_n.
  - Force step_q off by one -> err is set likewise.
